// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch front end
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // Bit positions of the fields pre-split for decode
  localparam int OP_LSB = 0;
  localparam int F3_LSB = 12;
  localparam int F7_LSB = 25;

  localparam int PC_INC = 4;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of {instr, pc} entries with flush
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   push, wdata      : write one entry (ignored when full)
//   pop              : drop the head entry (ignored when empty)
//   flush            : discard every entry; wins over push and pop
//   rdata            : head entry (meaningful only when !empty)
//   count/empty/full : occupancy status
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 wdata,
  input  logic                         pop,
  input  logic                         flush,
  output logic [W-1:0]                 rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage needs no reset: nothing reads it while the FIFO is empty
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their own
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: PC, imem requests, instruction buffer, redirect flush
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (adds fetch_misalign, rejects misaligned redirects)
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   imem_req_valid/ready/addr      : word request channel to instruction memory
//   imem_rsp_valid/data            : in-order responses, no backpressure
//   redirect_valid/pc              : one-cycle flush and restart from execute
//   dec_valid/ready                : handshake to decode
//   dec_instr/pc/op/funct3/funct7  : buffered head instruction and its pre-split fields
//   fetch_misalign                 : (macro only) pulse when a misaligned redirect is ignored
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [31:0]       dec_instr,
  output logic [ADDR_W-1:0] dec_pc,
  output logic [6:0]        dec_op,
  output logic [2:0]        dec_funct3,
  output logic [6:0]        dec_funct7
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic              fetch_misalign
`endif
);

  localparam int              CNT_W      = $clog2(FIFO_DEPTH+1);
  localparam logic [CNT_W:0]  CREDIT_MAX = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [ADDR_W-1:0] redir_target;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  drop_cnt, drop_nxt;
  logic [CNT_W-1:0]  occupancy;
  logic              redir_ok;
  logic              req_fire;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [31:0]       head_instr;
  logic [ADDR_W-1:0] head_pc;

  assign redir_target = redirect_pc & WORD_MASK;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = (redirect_pc[1:0] != 2'b00);
  assign redir_ok   = redirect_valid && (state != BOOT) && !misaligned;

  always_ff @(posedge clk) begin
    if (rst) fetch_misalign <= 1'b0;
    else     fetch_misalign <= redirect_valid && (state != BOOT) && misaligned;
  end
`else
  assign redir_ok = redirect_valid && (state != BOOT);
`endif

  always_comb begin
    state_nxt      = state;
    drop_nxt       = drop_cnt;
    // Credit counts both buffered and in-flight words, so a response always has a slot
    imem_req_valid = (state == FETCH) && !fifo_full && !redirect_valid &&
                     (({1'b0, occupancy} + {1'b0, outstanding}) < CREDIT_MAX);
    unique case (state)
      BOOT: state_nxt = FETCH;
      FETCH, DRAIN: begin
        if (redir_ok) begin
          // A response landing with the redirect is already stale, so it is not counted
          drop_nxt  = outstanding - CNT_W'(imem_rsp_valid);
          state_nxt = (drop_nxt != '0) ? DRAIN : FETCH;
        end else if ((state == DRAIN) && imem_rsp_valid) begin
          drop_nxt = drop_cnt - 1'b1;
          if (drop_nxt == '0) state_nxt = FETCH;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  assign req_fire      = imem_req_valid && imem_req_ready;
  assign imem_req_addr = pc;
  assign push          = imem_rsp_valid && (state == FETCH) && !redir_ok;
  assign pop           = dec_valid && dec_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state    <= state_nxt;
      drop_cnt <= drop_nxt;
      if (redir_ok)      pc <= redir_target;
      else if (req_fire) pc <= pc + ADDR_W'(PC_INC);
      // Responses are in order, so the PC of the next kept response is a running counter
      if (redir_ok)  rsp_pc <= redir_target;
      else if (push) rsp_pc <= rsp_pc + ADDR_W'(PC_INC);
      case ({req_fire, imem_rsp_valid})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32 + ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({imem_rsp_data, rsp_pc}),
    .pop   (pop),
    .flush (redir_ok),
    .rdata ({head_instr, head_pc}),
    .count (occupancy),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Outputs read zero whenever nothing is buffered
  assign dec_valid  = !fifo_empty;
  assign dec_instr  = dec_valid ? head_instr : '0;
  assign dec_pc     = dec_valid ? head_pc : '0;
  assign dec_op     = dec_instr[OP_LSB +: 7];
  assign dec_funct3 = dec_instr[F3_LSB +: 3];
  assign dec_funct7 = dec_instr[F7_LSB +: 7];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] RPC  = 32'h0000_0000;
  localparam logic [31:0] SALT = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_instr, dec_pc;
  logic [6:0]  dec_op, dec_funct7;
  logic [2:0]  dec_funct3;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W     (32),
    .FIFO_DEPTH (4),
    .RESET_PC   (RPC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_op         (dec_op),
    .dec_funct3     (dec_funct3),
    .dec_funct7     (dec_funct7)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  int checks = 0;
  int passes = 0;
  int lat = 1;
  bit rr_mode = 1'b0;
  int edge_n = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mreq_t;

  typedef struct {
    int          lat;
    int          pre;
    bit          rr;
    logic [31:0] rpc;
    logic [31:0] exp_first;
    bit          taken;
  } vec_t;

  mreq_t       mq[$];
  logic [63:0] sb[$];
  logic [31:0] req_hist[$];
  logic [31:0] dec_hist[$];
  logic [31:0] exp_pc = RPC;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rr_mode) imem_req_ready = 1'($urandom_range(0, 1));
    else         imem_req_ready = 1'b1;
  endtask

  always @(posedge clk) edge_n <= edge_n + 1;

  // Memory model and scoreboard, evaluated away from the rising edge
  always @(negedge clk) begin : mon
    mreq_t       r;
    logic [63:0] e;
    bit          stale_pending;
    bit          have;
    if (rst) begin
      mq.delete();
      sb.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      exp_pc         = RPC;
    end else begin
      if (dec_valid && dec_ready) begin
        have = (sb.size() != 0);
        chk("dec_expected", 32'(have), 32'd1);
        if (have) begin
          e = sb.pop_front();
          chk("dec_pc", dec_pc, e[63:32]);
          chk("dec_instr", dec_instr, e[31:0]);
          chk("dec_op", 32'(dec_op), 32'(e[6:0]));
          chk("dec_f3", 32'(dec_funct3), 32'(e[14:12]));
          chk("dec_f7", 32'(dec_funct7), 32'(e[31:25]));
        end
        dec_hist.push_back(dec_pc);
      end
      stale_pending = 1'b0;
      foreach (mq[i]) if (mq[i].stale) stale_pending = 1'b1;
      if (stale_pending) chk("no_req_in_drain", 32'(imem_req_valid), 32'd0);
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (mq.size() != 0 && mq[0].due == edge_n + 1) begin
        r = mq.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = r.addr ^ SALT;
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      if (redirect_valid && redirect_pc[1:0] == 2'b00) begin
`else
      if (redirect_valid) begin
`endif
        foreach (mq[i]) mq[i].stale = 1'b1;
        sb.delete();
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, exp_pc);
        mq.push_back('{addr: imem_req_addr, due: edge_n + 1 + lat, stale: 1'b0});
        sb.push_back({imem_req_addr, imem_req_addr ^ SALT});
        req_hist.push_back(imem_req_addr);
        exp_pc = exp_pc + 32'd4;
      end
    end
  end

  task automatic do_reset(input int l, input bit rr, input bit dr);
    rst = 1'b1;
    redirect_valid = 1'b0;
    lat = l;
    rr_mode = rr;
    dec_ready = dr;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [31:0] p);
    redirect_valid = 1'b1;
    redirect_pc = p;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_req(input int snap, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (req_hist.size() > snap) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_dec(input int snap, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (dec_hist.size() > snap) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, RPC);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_dec_instr", dec_instr, 32'd0);
    chk("rst_dec_pc", dec_pc, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst_misalign", 32'(fetch_misalign), 32'd0);
`endif
  endtask

  function automatic vec_t mkv(input int l, input int p, input bit rr,
                               input logic [31:0] rpc, input logic [31:0] ef, input bit tk);
    vec_t v;
    v.lat = l; v.pre = p; v.rr = rr; v.rpc = rpc; v.exp_first = ef; v.taken = tk;
    return v;
  endfunction

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    vec_t tv[5];
    int   snap, dsnap;
    bit   ok;

    tv[0] = mkv(1, 6, 1'b0, 32'h0000_0100, 32'h0000_0100, 1'b1);
    tv[1] = mkv(4, 5, 1'b0, 32'h0000_0100, 32'h0000_0100, 1'b1);
    tv[3] = mkv(2, 7, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1);
`ifdef FETCH_MISALIGN_CHECK_EN
    tv[2] = mkv(1, 9, 1'b0, 32'h0000_0102, 32'h0, 1'b0);
    tv[4] = mkv(3, 4, 1'b0, 32'h0000_2003, 32'h0, 1'b0);
`else
    tv[2] = mkv(1, 9, 1'b0, 32'h0000_0102, 32'h0000_0100, 1'b1);
    tv[4] = mkv(3, 4, 1'b0, 32'h0000_2003, 32'h0000_2000, 1'b1);
`endif

    rst = 1'b1; dec_ready = 1'b1; imem_req_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    tick();
    tick();
    chk_reset_outputs();

    // Free run from reset on a single-cycle memory
    rst = 1'b0;
    chk("boot_no_req", 32'(imem_req_valid), 32'd0);
    tick();
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, RPC);
    tick();
    chk("dec_valid_c2", 32'(dec_valid), 32'd0);
    tick();
    chk("dec_valid_c3", 32'(dec_valid), 32'd1);
    chk("dec_pc_c3", dec_pc, RPC);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("stream_rate", 32'(dec_valid), 32'd1);
    end

    // Backpressure: credit stops issue at four words
    do_reset(1, 1'b0, 1'b0);
    snap = req_hist.size();
    repeat (12) tick();
    chk("bp_req_count", 32'(req_hist.size() - snap), 32'd4);
    chk("bp_req_stalled", 32'(imem_req_valid), 32'd0);
    chk("bp_dec_valid", 32'(dec_valid), 32'd1);
    dsnap = dec_hist.size();
    dec_ready = 1'b1;
    repeat (8) tick();
    chk("bp_resume", 32'(req_hist.size() - snap > 4), 32'd1);
    chk("bp_first_out", dec_hist[dsnap], RPC);
    chk("bp_fourth_out", dec_hist[dsnap + 3], RPC + 32'd12);

    // Redirect table
    for (int v = 0; v < 5; v++) begin
      do_reset(tv[v].lat, tv[v].rr, 1'b1);
      repeat (tv[v].pre) tick();
      snap = req_hist.size();
      pulse(tv[v].rpc);
      dsnap = dec_hist.size();
      if (tv[v].taken) begin
        wait_req(snap, ok);
        chk("redir_req_seen", 32'(ok), 32'd1);
        if (ok) chk("redir_first_req", req_hist[snap], tv[v].exp_first);
        wait_dec(dsnap, ok);
        chk("redir_dec_seen", 32'(ok), 32'd1);
        if (ok) chk("redir_first_dec", dec_hist[dsnap], tv[v].exp_first);
      end else begin
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("misalign_pulse", 32'(fetch_misalign), 32'd1);
        tick();
        chk("misalign_clear", 32'(fetch_misalign), 32'd0);
`endif
        repeat (8) tick();
      end
      repeat (6) tick();
    end

    // Second redirect while draining the first
    do_reset(4, 1'b0, 1'b1);
    repeat (7) tick();
    snap = req_hist.size();
    pulse(32'h0000_0300);
    pulse(32'h0000_0400);
    dsnap = dec_hist.size();
    wait_req(snap, ok);
    chk("drain_redir_req_seen", 32'(ok), 32'd1);
    if (ok) chk("drain_redir_first_req", req_hist[snap], 32'h0000_0400);
    wait_dec(dsnap, ok);
    chk("drain_redir_dec_seen", 32'(ok), 32'd1);
    if (ok) chk("drain_redir_first_dec", dec_hist[dsnap], 32'h0000_0400);
    repeat (6) tick();

    // Reset while draining
    do_reset(4, 1'b0, 1'b1);
    repeat (7) tick();
    pulse(32'h0000_0100);
    rst = 1'b1;
    tick();
    chk_reset_outputs();
    snap = req_hist.size();
    rst = 1'b0;
    wait_req(snap, ok);
    chk("post_rst_req_seen", 32'(ok), 32'd1);
    if (ok) chk("post_rst_first_req", req_hist[snap], RPC);
    repeat (6) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
